// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host request/response and SPI pin bundle for spi_master
interface spi_master_if;
  logic        start;
  logic        rw;
  logic [6:0]  addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        sclk;
  logic        csz;
  logic        sdi;
  logic        sdo;

  modport master (
    input  start, rw, addr, wdata, sdo,
    output busy, done, rdata, sclk, csz, sdi
  );

  modport slave (
    output start, rw, addr, wdata, sdo,
    input  busy, done, rdata, sclk, csz, sdi
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - 24-bit SPI master: addr[6:0], rw, 16 data bits, MSB first
// sclk idles low; sdo is captured on the clk edge that raises sclk.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [4:0] BIT_LAST = 5'd23;
  localparam logic [4:0] BIT_DATA = 5'd8;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [23:0] sreg_q, sreg_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rw_q, rw_d;
  logic        done_q, done_d;

  logic sclk_c, csz_c, sdi_c, busy_c, done_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sreg_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sreg_q  <= sreg_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sreg_d  = sreg_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    done_d  = 1'b0;
    sclk_c  = 1'b0;
    csz_c   = 1'b1;
    sdi_c   = 1'b1;
    busy_c  = 1'b0;
    done_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_q marks the single IDLE cycle following GAP
        done_c = done_q;
        if (bus.start) begin
          state_d = SHIFT;
          sreg_d  = {bus.addr, bus.rw, bus.wdata};
          rw_d    = bus.rw;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end
      end

      SHIFT: begin
        busy_c = 1'b1;
        csz_c  = 1'b0;
        sclk_c = phase_q;
        sdi_c  = sreg_q[23];
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            if (bit_q >= BIT_DATA)
              cap_d = {cap_q[14:0], bus.sdo};
          end else begin
            // Next bit is presented on the same cycle sclk falls
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = CS_HOLD;
              bit_d   = '0;
            end else begin
              bit_d  = bit_q + 5'd1;
              sreg_d = {sreg_q[22:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      CS_HOLD: begin
        busy_c = 1'b1;
        csz_c  = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = GAP;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      GAP: begin
        busy_c = 1'b1;
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          if (rw_q)
            rdata_d = cap_q;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sclk  = sclk_c;
  assign bus.csz   = csz_c;
  assign bus.sdi   = sdi_c;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.rdata = rdata_q;

endmodule
